hwag_vr_gen: RTL and testbench

- Crank trigger-wheel emulator: the transmitting end of the VR sensor path.
- Synthesises a toothed-wheel pulse train (e.g. 60-2) with programmable tooth period, pulse width, tooth count and missing-tooth gap.
- Drives the angle generator's vr_in in self-test and bench setups.
- Also reports the emulated tooth position, so a bench can check the capture, gap-search and angle-counter outputs against the known true position.

---
 rtl/hwag_vr_gen.sv | 183 ++++++++++++++++++
 tb/tb_hwag_vr_gen.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwag_vr_gen.sv
// hwag_vr_gen: crank trigger-wheel emulator (transmitting end of the VR path).
// Produces a toothed-wheel pulse train (e.g. 60-2) with a programmable tooth
// period, high time, tooth count and missing-tooth gap. It also reports the
// emulated tooth position, so downstream capture/gap logic can be checked.
// Optional feature: define HWAG_VR_GEN_ACCEL_EN to add a per-tooth period
// ramp (cfg_step, cfg_pmin) that is applied at every tooth boundary.
module hwag_vr_gen #(
  parameter int PW = 24,
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          load,
  input  logic [PW-1:0] cfg_period,
  input  logic [PW-1:0] cfg_high,
  input  logic [TW-1:0] cfg_total,
  input  logic [TW-1:0] cfg_missing,
`ifdef HWAG_VR_GEN_ACCEL_EN
  input  logic [15:0]   cfg_step,
  input  logic [PW-1:0] cfg_pmin,
`endif
  output logic          vr_out,
  output logic          tooth_strobe,
  output logic          gap_strobe,
  output logic [TW-1:0] tooth_num,
  output logic          running,
  output logic          cfg_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic [PW-1:0] period;
    logic [PW-1:0] high;
    logic [TW-1:0] total;
    logic [TW-1:0] missing;
`ifdef HWAG_VR_GEN_ACCEL_EN
    logic [15:0]   step;
    logic [PW-1:0] pmin;
`endif
  } cfg_t;

  state_t        state, state_nx;
  cfg_t          act, act_nx, pend, cfg_in;
  logic          act_valid, pend_new, load_ok, apply_pend, wrap;
  logic [PW-1:0] pcnt, pcnt_nx;
  logic [TW-1:0] pos, pos_nx;
  logic          vr_nx, strobe_nx, real_tooth;

`ifdef HWAG_VR_GEN_ACCEL_EN
  // Next tooth period: current period plus signed step, saturated to
  // [max(pmin, high+1), 2^PW-1] so the ramp can never wrap.
  function automatic logic [PW-1:0] ramp_period(input cfg_t c);
    logic signed [PW+1:0] sum;
    logic signed [PW+1:0] lo;
    logic signed [PW+1:0] hi;
    logic [PW-1:0]        floor_p;
    floor_p = (c.pmin > c.high + PW'(1)) ? c.pmin : c.high + PW'(1);
    sum = $signed({2'b00, c.period}) + $signed({{(PW+2-16){c.step[15]}}, c.step});
    lo  = $signed({2'b00, floor_p});
    hi  = $signed({2'b00, {PW{1'b1}}});
    if (sum < lo)      ramp_period = floor_p;
    else if (sum > hi) ramp_period = {PW{1'b1}};
    else               ramp_period = sum[PW-1:0];
  endfunction
`endif

  // Gather the cfg_* inputs into one record and check it for validity.
  always_comb begin
    cfg_in         = '0;
    cfg_in.period  = cfg_period;
    cfg_in.high    = cfg_high;
    cfg_in.total   = cfg_total;
    cfg_in.missing = cfg_missing;
`ifdef HWAG_VR_GEN_ACCEL_EN
    cfg_in.step    = cfg_step;
    cfg_in.pmin    = cfg_pmin;
`endif
    load_ok = (cfg_period >= PW'(2)) && (cfg_high != '0) && (cfg_high < cfg_period) &&
              (cfg_total >= TW'(3)) &&
              (({1'b0, cfg_missing} + (TW+1)'(2)) <= {1'b0, cfg_total});
  end

  assign wrap = (state == RUN) && (pcnt == act.period - PW'(1));

  // Next state, counters, active config and the values the outputs take next.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_nx   = state;
    pcnt_nx    = '0;
    pos_nx     = '0;
    act_nx     = act;
    apply_pend = 1'b0;
    vr_nx      = 1'b0;
    strobe_nx  = 1'b0;
    real_tooth = 1'b0;
    case (state)
      IDLE: begin
        if (pend_new) begin
          act_nx     = pend;
          apply_pend = 1'b1;
        end
        if (ena && act_valid) state_nx = RUN;
      end
      RUN: begin
        if (!ena) begin
          state_nx = IDLE;
        end else if (wrap) begin
          pos_nx = (pos == act.total - TW'(1)) ? '0 : pos + TW'(1);
          if (pend_new) begin
            act_nx     = pend;
            apply_pend = 1'b1;
          end
`ifdef HWAG_VR_GEN_ACCEL_EN
          else begin
            act_nx.period = ramp_period(act);
          end
`endif
          // A freshly applied, shorter wheel restarts at position 0.
          if (pos_nx >= act_nx.total) pos_nx = '0;
        end else begin
          pcnt_nx = pcnt + PW'(1);
          pos_nx  = pos;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx == RUN) begin
      real_tooth = pos_nx < (act_nx.total - act_nx.missing);
      vr_nx      = real_tooth && (pcnt_nx < act_nx.high);
      strobe_nx  = real_tooth && (pcnt_nx == '0);
    end
  end

  // State register, tooth counters, active config and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (rst) begin
      state        <= IDLE;
      pcnt         <= '0;
      pos          <= '0;
      act          <= '0;
      act_valid    <= 1'b0;
      vr_out       <= 1'b0;
      tooth_strobe <= 1'b0;
      gap_strobe   <= 1'b0;
    end else begin
      state        <= state_nx;
      pcnt         <= pcnt_nx;
      pos          <= pos_nx;
      act          <= act_nx;
      act_valid    <= act_valid | apply_pend;
      vr_out       <= vr_nx;
      tooth_strobe <= strobe_nx;
      gap_strobe   <= strobe_nx & (pos_nx == '0);
    end
  end

  // Pending config capture; a load on an apply cycle waits for the next boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      pend_new <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      if (load) begin
        if (load_ok) begin
          pend    <= cfg_in;
          cfg_err <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      if (load && load_ok) pend_new <= 1'b1;
      else if (apply_pend) pend_new <= 1'b0;
    end
  end

  assign tooth_num = pos;
  assign running   = (state == RUN);

endmodule

// File: tb/tb_hwag_vr_gen.sv
// Self-checking bench for hwag_vr_gen: directed scenarios plus randomized
// load/enable/reset traffic, compared every cycle against a tooth-timeline model.
module tb_hwag_vr_gen;
  localparam int PW = 24;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic          load = 1'b0;
  logic [PW-1:0] cfg_period = '0;
  logic [PW-1:0] cfg_high = '0;
  logic [TW-1:0] cfg_total = '0;
  logic [TW-1:0] cfg_missing = '0;
`ifdef HWAG_VR_GEN_ACCEL_EN
  logic [15:0]   cfg_step = '0;
  logic [PW-1:0] cfg_pmin = '0;
`endif
  logic          vr_out, tooth_strobe, gap_strobe, running, cfg_err;
  logic [TW-1:0] tooth_num;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hwag_vr_gen #(.PW(PW), .TW(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .load         (load),
    .cfg_period   (cfg_period),
    .cfg_high     (cfg_high),
    .cfg_total    (cfg_total),
    .cfg_missing  (cfg_missing),
`ifdef HWAG_VR_GEN_ACCEL_EN
    .cfg_step     (cfg_step),
    .cfg_pmin     (cfg_pmin),
`endif
    .vr_out       (vr_out),
    .tooth_strobe (tooth_strobe),
    .gap_strobe   (gap_strobe),
    .tooth_num    (tooth_num),
    .running      (running),
    .cfg_err      (cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: a wheel described by the start cycle of the current tooth
  // and its position; a tooth ends once 'period' cycles have elapsed.
  typedef struct {
    int period;
    int high;
    int total;
    int missing;
    int step;
    int pmin;
  } mcfg_t;

  mcfg_t m_act, m_pend;
  bit    m_act_valid = 0, m_pend_new = 0, m_run = 0, m_err = 0;
  int    m_start = 0, m_pos = 0, cyc = 0;

  // Observations of the DUT waveform for interval checks.
  int  last_tooth_cyc = 0, tooth_len = 0, last_gap_cyc = 0, rev_len = 0;
  int  since_gap = 0, rev_pulses = 0, rise_cyc = 0, fall_cyc = 0, hi_len = 0, low_len = 0;
  bit  prev_vr = 0;

  function automatic bit cfg_ok(input mcfg_t c);
    return c.period >= 2 && c.high >= 1 && c.high <= c.period - 1 &&
           c.total >= 3 && c.missing <= c.total - 2;
  endfunction

  function automatic mcfg_t cur_cfg();
    mcfg_t c;
    c.period  = int'(cfg_period);
    c.high    = int'(cfg_high);
    c.total   = int'(cfg_total);
    c.missing = int'(cfg_missing);
    c.step    = 0;
    c.pmin    = 0;
`ifdef HWAG_VR_GEN_ACCEL_EN
    c.step    = int'($signed(cfg_step));
    c.pmin    = int'(cfg_pmin);
`endif
    return c;
  endfunction

`ifdef HWAG_VR_GEN_ACCEL_EN
  function automatic int ramped(input mcfg_t c);
    longint s, lo, hi;
    s  = longint'(c.period) + longint'(c.step);
    lo = (c.pmin > c.high + 1) ? c.pmin : c.high + 1;
    hi = (longint'(1) << PW) - 1;
    if (s < lo) s = lo;
    if (s > hi) s = hi;
    return int'(s);
  endfunction
`endif

  task automatic model_edge();
    mcfg_t c, p;
    bit    was_new, took, applied, can_start;
    cyc++;
    if (rst) begin
      m_run = 0; m_act_valid = 0; m_pend_new = 0; m_err = 0; m_pos = 0;
      return;
    end
    c = cur_cfg();
    p = m_pend;
    was_new = m_pend_new;
    took = 0;
    applied = 0;
    if (load) begin
      if (cfg_ok(c)) begin m_pend = c; took = 1; m_err = 0; end
      else m_err = 1;
    end
    if (!m_run) begin
      can_start = ena && m_act_valid;
      if (was_new) begin m_act = p; m_act_valid = 1; applied = 1; end
      if (can_start) begin m_run = 1; m_start = cyc; m_pos = 0; end
    end else if (!ena) begin
      m_run = 0; m_pos = 0;
    end else if (cyc - m_start == m_act.period) begin
      m_pos = (m_pos + 1) % m_act.total;
      if (was_new) begin m_act = p; applied = 1; end
`ifdef HWAG_VR_GEN_ACCEL_EN
      else m_act.period = ramped(m_act);
`endif
      if (m_pos >= m_act.total) m_pos = 0;
      m_start = cyc;
    end
    if (took) m_pend_new = 1;
    else if (applied) m_pend_new = 0;
  endtask

  // One clock: advance the model on the edge, then compare every output.
  task automatic step();
    bit e_vr, e_ts, e_gs, e_run, is_real;
    int e_num, off;
    @(posedge clk);
    model_edge();
    #1;
    e_vr = 0; e_ts = 0; e_gs = 0; e_run = 0; e_num = 0;
    if (m_run) begin
      off     = cyc - m_start;
      is_real = m_pos < m_act.total - m_act.missing;
      e_vr    = is_real && off < m_act.high;
      e_ts    = is_real && off == 0;
      e_gs    = e_ts && m_pos == 0;
      e_num   = m_pos;
      e_run   = 1;
    end
    check("vr_out", vr_out, e_vr);
    check("tooth_strobe", tooth_strobe, e_ts);
    check("gap_strobe", gap_strobe, e_gs);
    check("tooth_num", tooth_num, e_num);
    check("running", running, e_run);
    check("cfg_err", cfg_err, m_err);
    if (gap_strobe === 1'b1) begin
      rev_len = cyc - last_gap_cyc; last_gap_cyc = cyc;
      rev_pulses = since_gap; since_gap = 0;
    end
    if (tooth_strobe === 1'b1) begin
      tooth_len = cyc - last_tooth_cyc; last_tooth_cyc = cyc;
      since_gap++;
    end
    if (vr_out === 1'b1 && !prev_vr) begin rise_cyc = cyc; low_len = cyc - fall_cyc; end
    if (vr_out === 1'b0 && prev_vr)  begin fall_cyc = cyc; hi_len = cyc - rise_cyc; end
    prev_vr = (vr_out === 1'b1);
  endtask

  task automatic drive_cfg(input int p, input int h, input int t, input int m,
                           input int st, input int pm);
    cfg_period  = PW'(p);
    cfg_high    = PW'(h);
    cfg_total   = TW'(t);
    cfg_missing = TW'(m);
`ifdef HWAG_VR_GEN_ACCEL_EN
    cfg_step    = 16'(st);
    cfg_pmin    = PW'(pm);
`endif
  endtask

  task automatic do_load(input int p, input int h, input int t, input int m,
                         input int st = 0, input int pm = 0);
    drive_cfg(p, h, t, m, st, pm);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Step until the DUT strobes tooth n, bounded by a cycle budget.
  task automatic wait_tooth(input int n, input int budget, input string tag);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = (tooth_strobe === 1'b1) && (tooth_num == TW'(n));
    end
    check(tag, seen, 1'b1);
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_vr_out", vr_out, 1'b0);
    check("rst_running", running, 1'b0);

    // 1: 10/4, 8-2 wheel.
    do_load(10, 4, 8, 2);
    step();
    ena = 1'b1;
    step();
    check("t1_first_vr", vr_out, 1'b1);
    check("t1_first_gap", gap_strobe, 1'b1);
    check("t1_first_num", tooth_num, 0);
    wait_tooth(0, 200, "t1_next_rev");
    check("t1_rev_len", rev_len, 80);
    check("t1_pulses", rev_pulses, 6);
    check("t1_gap_low", low_len, 26);
    check("t1_high", hi_len, 4);

    // 2: rejected load, then a valid one.
    do_load(10, 10, 8, 2);
    check("t2_err_set", cfg_err, 1'b1);
    wait_tooth(3, 100, "t2_run");
    check("t2_tooth_len", tooth_len, 10);
    do_load(10, 4, 8, 2);
    check("t2_err_clr", cfg_err, 1'b0);

    // 3: period change mid-tooth applies at the next boundary.
    wait_tooth(2, 100, "t3_sync");
    repeat (3) step();
    do_load(20, 4, 8, 2);
    wait_tooth(3, 100, "t3_tooth3");
    check("t3_old_len", tooth_len, 10);
    wait_tooth(4, 100, "t3_tooth4");
    check("t3_new_len", tooth_len, 20);
    check("t3_high", hi_len, 4);

    // 4: stop mid-tooth, then restart at tooth 0.
    repeat (2) step();
    ena = 1'b0;
    step();
    check("t4_stop_vr", vr_out, 1'b0);
    check("t4_stop_num", tooth_num, 0);
    check("t4_stop_run", running, 1'b0);
    ena = 1'b1;
    step();
    check("t4_restart_gap", gap_strobe, 1'b1);
    check("t4_restart_num", tooth_num, 0);

    // 5: no missing teeth.
    ena = 1'b0;
    step();
    do_load(5, 2, 4, 0);
    step();
    ena = 1'b1;
    step();
    check("t5_start_gap", gap_strobe, 1'b1);
    wait_tooth(1, 50, "t5_tooth1");
    check("t5_pitch", tooth_len, 5);
    wait_tooth(0, 50, "t5_rev");
    check("t5_rev_len", rev_len, 20);
    check("t5_pulses", rev_pulses, 4);

    // Randomized traffic: loads (valid and invalid), enable toggles, resets.
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 249) == 0);
      load = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 59) == 0) ena = ~ena;
      drive_cfg($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 10),
                $urandom_range(0, 9), $urandom_range(0, 80) - 40, $urandom_range(0, 12));
      step();
    end
    rst  = 1'b0;
    load = 1'b0;

    // 6: reset overrides load and ena mid-high.
    ena = 1'b0;
    step();
    do_load(10, 4, 8, 2);
    step();
    ena = 1'b1;
    step(); step();
    check("t6_pre_high", vr_out, 1'b1);
    drive_cfg(10, 4, 8, 2, 0, 0);
    rst = 1'b1; load = 1'b1;
    step();
    rst = 1'b0; load = 1'b0;
    check("t6_rst_vr", vr_out, 1'b0);
    check("t6_rst_strobe", tooth_strobe, 1'b0);
    check("t6_rst_run", running, 1'b0);
    check("t6_rst_num", tooth_num, 0);
    repeat (12) step();
    check("t6_no_restart", running, 1'b0);

`ifdef HWAG_VR_GEN_ACCEL_EN
    // Ramp: 100, 70, then clamped at pmin 50.
    ena = 1'b0;
    step();
    do_load(100, 10, 8, 2, -30, 50);
    step();
    ena = 1'b1;
    step();
    wait_tooth(1, 300, "acc_t1");
    check("acc_len0", tooth_len, 100);
    wait_tooth(2, 300, "acc_t2");
    check("acc_len1", tooth_len, 70);
    wait_tooth(3, 300, "acc_t3");
    check("acc_len2", tooth_len, 50);
    wait_tooth(4, 300, "acc_t4");
    check("acc_len3", tooth_len, 50);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
